dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit between the RV32 core datapath and the word-addressed data memory. It accepts one byte, halfword or word access at a time over a valid/ready request channel. It performs sign/zero extension on loads and read-modify-write for sub-word stores. The memory itself only does full-word writes on a word index, with combinational read. Misaligned, illegal-funct3 and out-of-range accesses return an error response and never write memory.

## Interface
- DEPTH, 64, number of 32-bit words in the data memory; word index must be < DEPTH
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  core presents a request
- req_ready  output  1  LSU can accept; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32 funct3: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle pulse, response fields valid
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  access rejected
- mem_address  output  32  word index = req_addr >> 2
- mem_memwrite  output  1  full-word write strobe
- mem_write_data  output  32  word to write
- mem_read_data  input  32  combinational read of word at mem_address

## Operation
- States: IDLE, READ, WRITE, LOAD, RESP.
- IDLE: req_ready=1. On req_valid, latch write, funct3, addr, wdata and classify the request.
- Error if any of these holds:
  - funct3 is not in the legal set (stores: 000/001/010 only; loads: 000/001/010/100/101);
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr>>2 ≥ DEPTH.
- On error: go to RESP with resp_error=1.
- Otherwise:
  - load → LOAD;
  - SW → WRITE;
  - SB/SH → READ.
- LOAD: drive mem_address and sample mem_read_data the same cycle. Extract the byte/half at addr[1:0] and sign- or zero-extend per funct3. Then go to RESP.
- READ: sample the old word, then go to WRITE.
- WRITE: mem_memwrite=1 for exactly one cycle. Data is either the merged word (the new byte/half inserted at lane addr[1:0], other lanes from the old word) or req_wdata for SW. Then go to RESP.
- RESP: resp_valid=1, then unconditionally go to IDLE. There is no backpressure on the response.
- mem_address holds the latched word index in every non-IDLE state and is 0 in IDLE.
- mem_memwrite is 0 in every state except WRITE.

## Timing
- Accept at edge N, i.e. the rising edge at which req_valid & req_ready are sampled high. Counting from that edge, resp_valid is high in:
  - cycle N+1 for errors;
  - cycle N+2 for loads and SW;
  - cycle N+3 for SB/SH.
- mem_memwrite is high in:
  - cycle N+1 for SW;
  - cycle N+2 for SB/SH.
- The next request can be accepted in the cycle after resp_valid; there is no overlap.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_address=0, mem_memwrite=0, mem_write_data=0.
- Reset asserted mid-operation returns to IDLE immediately and drops mem_memwrite asynchronously. A pending write is lost, and no partial merge reaches memory.
- req_valid while not ready is ignored; the core must hold the request until accepted.

## Structure
- Package dmem_lsu_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enumeration.
- Sub-module lsu_align is purely combinational and has two functions:
  - load extract/extend: word, offset, funct3 → 32-bit result;
  - store merge: old word, wdata, offset, funct3 → new word.
- The FSM and registers live in dmem_lsu.

## Test plan
- LW at addr 0x10 with mem word 4 = 0xDEADBEEF → resp_rdata=0xDEADBEEF, resp_valid in cycle N+2, no mem_memwrite.
- LB at 0x13 and LBU at 0x13, word 4 = 0x80112233 → LB gives 0xFFFFFF80, LBU gives 0x00000080.
- SB of 0xAB to 0x21, word 8 = 0x11223344 → READ then WRITE; mem_write_data=0x1122AB44; resp_valid in cycle N+3.
- SH to 0x05 and LW from 0x02 → both resp_error=1, mem_memwrite never asserted, resp_rdata=0.
- SW to byte addr 0x100 with DEPTH=64 (word index 64) → resp_error=1, no write.
- Assert reset_n low during the WRITE state of an SB → mem_memwrite drops immediately, memory word unchanged, LSU in IDLE with req_ready=1 after release.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared constants and types for the data-memory load/store unit.
package dmem_lsu_pkg;

    // RV32 load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        LOAD,
        RESP
    } lsu_state_t;

    // Stores only have signed-width encodings; loads add the unsigned variants
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!is_store) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if ((f3 == F3_H) || (f3 == F3_HU)) begin
            bad = off[0];
        end else if (f3 == F3_W) begin
            bad = (off != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane alignment: load extract/extend and sub-word store merge.
module lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed lane and extend it according to funct3
    always_comb begin
        lane_b    = word[{offset, 3'b000} +: 8];
        lane_h    = word[{offset[1], 4'b0000} +: 16];
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h000000, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0000, lane_h};
            default: load_data = word;
        endcase
    end

    // Insert the new byte/half into the old word, other lanes untouched
    always_comb begin
        store_word = word;
        case (funct3)
            F3_B:    store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_H:    store_word[{offset[1], 4'b0000} +: 16] = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the RV32 datapath and a word-addressed data memory.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic        mem_memwrite,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    // Classify the request presented in IDLE
    always_comb begin
        req_err = !f3_legal(req_write, req_funct3)
               || f3_misaligned(req_funct3, req_addr[1:0])
               || ({2'b00, req_addr[31:2]} >= DEPTH);
    end

    lsu_align u_align (
        .word       (mem_read_data),
        .wdata      (wdata_q),
        .offset     (off_q),
        .funct3     (f3_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Request sequencing with registered core and memory outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            f3_q           <= '0;
            off_q          <= '0;
            wdata_q        <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
            mem_address    <= '0;
            mem_memwrite   <= 1'b0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q        <= req_funct3;
                        off_q       <= req_addr[1:0];
                        wdata_q     <= req_wdata[15:0];
                        mem_address <= {2'b00, req_addr[31:2]};
                        req_ready   <= 1'b0;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_write) begin
                            state <= LOAD;
                        end else if (req_funct3 == F3_W) begin
                            state          <= WRITE;
                            mem_memwrite   <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= load_data;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                READ: begin
                    mem_write_data <= store_word;
                    mem_memwrite   <= 1'b1;
                    state          <= WRITE;
                end
                WRITE: begin
                    mem_memwrite <= 1'b0;
                    resp_rdata   <= '0;
                    resp_valid   <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    resp_valid  <= 1'b0;
                    resp_error  <= 1'b0;
                    resp_rdata  <= '0;
                    mem_address <= '0;
                    req_ready   <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    mem_memwrite <= 1'b0;
                    req_ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized self-checking bench for dmem_lsu with an arithmetic reference model.
module tb_dmem_lsu;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic        mem_memwrite;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_val;

    int n_cmp;
    int n_bad;

    dmem_lsu #(.DEPTH(64)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_address    (mem_address),
        .mem_memwrite   (mem_memwrite),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, full-word write, plus a backdoor preload port
    assign mem_read_data = (mem_address < 32'd64) ? mem[mem_address[5:0]] : 32'h0;
    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        else if (mem_memwrite && (mem_address < 32'd64)) mem[mem_address[5:0]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_word(input int unsigned i, input logic [31:0] v);
        bd_idx = 6'(i);
        bd_val = v;
        bd_we  = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
        ref_mem[i] = v;
    endtask

    // One request: model the expected response from the funct3/address rules, then observe 6 cycles
    task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] idx, old, sh, hsh, b, h, mask, exp_rd, exp_wd;
        logic        legal, half, word, exp_err;
        int          exp_resp, exp_wcyc, k;
        int          resp_cyc, resp_cnt, wcyc, wcnt;
        logic [31:0] got_rd, got_wd, got_addr;
        logic        got_err;

        idx   = addr / 4;
        old   = (idx < 64) ? ref_mem[idx] : 32'h0;
        legal = wr ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
        half  = (f3 == 3'd1) || (f3 == 3'd5);
        word  = (f3 == 3'd2);
        exp_err = !legal || (half && (addr % 2 != 0)) || (word && (addr % 4 != 0)) || (idx >= 64);

        sh  = (addr % 4) * 8;
        hsh = (addr & 32'd2) * 8;
        b   = (old >> sh) & 32'hFF;
        h   = (old >> hsh) & 32'hFFFF;
        exp_rd   = 32'h0;
        exp_wd   = old;
        exp_wcyc = 0;
        if (exp_err) begin
            exp_resp = 1;
        end else if (!wr) begin
            exp_resp = 2;
            case (f3)
                3'd0:    exp_rd = (b >= 128) ? b - 32'd256 : b;
                3'd4:    exp_rd = b;
                3'd1:    exp_rd = (h >= 32768) ? h - 32'd65536 : h;
                3'd5:    exp_rd = h;
                default: exp_rd = old;
            endcase
        end else if (word) begin
            exp_resp = 2;
            exp_wcyc = 1;
            exp_wd   = wd;
        end else begin
            exp_resp = 3;
            exp_wcyc = 2;
            if (half) begin
                mask   = 32'hFFFF << hsh;
                exp_wd = (old & ~mask) | ((wd & 32'hFFFF) << hsh);
            end else begin
                mask   = 32'hFF << sh;
                exp_wd = (old & ~mask) | ((wd & 32'hFF) << sh);
            end
        end

        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);

        resp_cyc = 0; resp_cnt = 0; wcyc = 0; wcnt = 0;
        got_rd = '0; got_wd = '0; got_addr = '0; got_err = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_wdata = $urandom;
            end
            if (resp_valid) begin
                resp_cnt++;
                if (resp_cyc == 0) begin
                    resp_cyc = c;
                    got_rd   = resp_rdata;
                    got_err  = resp_error;
                    got_addr = mem_address;
                end
            end
            if (mem_memwrite) begin
                wcnt++;
                if (wcyc == 0) begin
                    wcyc   = c;
                    got_wd = mem_write_data;
                end
            end
        end

        check("resp_cycle", 32'(resp_cyc), 32'(exp_resp));
        check("resp_pulses", 32'(resp_cnt), 32'd1);
        check("resp_error", 32'(got_err), 32'(exp_err));
        check("resp_rdata", got_rd, exp_rd);
        check("mem_address", got_addr, idx);
        check("write_cycle", 32'(wcyc), 32'(exp_wcyc));
        check("write_pulses", 32'(wcnt), (exp_wcyc != 0) ? 32'd1 : 32'd0);
        if (exp_wcyc != 0) begin
            check("write_data", got_wd, exp_wd);
            ref_mem[idx] = exp_wd;
        end
        if (idx < 64) check("mem_word", mem[idx[5:0]], ref_mem[idx]);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;
        bd_we      = 1'b0;
        bd_idx     = '0;
        bd_val     = '0;

        for (int unsigned i = 0; i < 64; i++) set_word(i, $urandom);

        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_memwrite", 32'(mem_memwrite), 32'd0);
        check("rst_mem_write_data", mem_write_data, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);

        // Directed cases
        set_word(4, 32'hDEADBEEF);
        run_op(1'b0, 3'd2, 32'h10, 32'h0);
        set_word(4, 32'h80112233);
        run_op(1'b0, 3'd0, 32'h13, 32'h0);
        run_op(1'b0, 3'd4, 32'h13, 32'h0);
        set_word(8, 32'h11223344);
        run_op(1'b1, 3'd0, 32'h21, 32'h000000AB);
        check("sb_merge_word", ref_mem[8], 32'h1122AB44);
        run_op(1'b1, 3'd1, 32'h05, 32'h12345678);
        run_op(1'b0, 3'd2, 32'h02, 32'h0);
        run_op(1'b1, 3'd2, 32'h100, 32'hCAFEF00D);
        run_op(1'b1, 3'd4, 32'h08, 32'h55);
        run_op(1'b0, 3'd7, 32'h08, 32'h0);
        run_op(1'b0, 3'd5, 32'hFE, 32'h0);
        run_op(1'b1, 3'd1, 32'hFE, 32'hBEEF);

        // Reset during the WRITE cycle of an SB
        set_word(9, 32'hA5A5A5A5);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h25;
        req_wdata  = 32'h3C;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_memwrite", 32'(mem_memwrite), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_memwrite_drop", 32'(mem_memwrite), 32'd0);
        check("async_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mid_word", mem[9], 32'hA5A5A5A5);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_address", mem_address, 32'd0);
        check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
        run_op(1'b0, 3'd2, 32'h24, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 255));
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        for (int unsigned i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
